uart_rx: RTL and testbench

//  Asynchronous serial receiver: 8N1 frames, LSB first, idle-high line. Inverse of uart_tx;

---
 rtl/uart_rx_if.sv | 28 ++
 rtl/uart_rx.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side serial link bundle: the line input plus the byte/status outputs.
// The receiver takes the master side; the frame parser takes the slave side.
interface uart_rx_if;
    logic       RxD;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic       RxD_frame_error;
    logic       RxD_idle;
    logic       RxD_endofpacket;

    modport master (
        input  RxD,
        output RxD_data_ready,
        output RxD_data,
        output RxD_frame_error,
        output RxD_idle,
        output RxD_endofpacket
    );

    modport slave (
        output RxD,
        input  RxD_data_ready,
        input  RxD_data,
        input  RxD_frame_error,
        input  RxD_idle,
        input  RxD_endofpacket
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with glitch-start rejection, framing-error flag and
// inter-packet gap detection; includes the fractional-rate tick generator it uses.

module uart_baud #(
    parameter int unsigned ClkFrequency = 12000000,
    parameter int unsigned TickRate     = 8000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);
    // Phase accumulator: exact long-term rate even when clk/TickRate is not an integer.
    localparam logic [32:0] Inc  = 33'(TickRate);
    localparam logic [32:0] Wrap = 33'(ClkFrequency);

    logic [32:0] acc;
    logic [32:0] accSum;

    always_comb accSum = acc + Inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (enable) begin
            if (accSum >= Wrap) begin
                acc  <= accSum - Wrap;
                tick <= 1'b1;
            end else begin
                acc  <= accSum;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end
endmodule

module uart_rx #(
    parameter int unsigned ClkFrequency = 12000000,
    parameter int unsigned Baud         = 2000000,
    parameter int unsigned Oversampling = 4,
    parameter int unsigned GapBits      = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master bus
);
    localparam int unsigned OsW    = $clog2(Oversampling);
    localparam int unsigned GapMax = GapBits * Oversampling;
    localparam int unsigned GapW   = $clog2(GapMax + 1);

    localparam logic [OsW-1:0]  OsLast = OsW'(Oversampling - 1);
    localparam logic [OsW-1:0]  OsHalf = OsW'(Oversampling / 2 - 1);
    localparam logic [GapW-1:0] GapSat = GapW'(GapMax);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_t;

    state_t     state, stateNext;
    logic [1:0] rxSync;
    logic       rxs;
    logic       osTick;

    logic [OsW-1:0]  osCnt, osNext;
    logic [2:0]      bitCnt, bitNext;
    logic [7:0]      shiftReg, shiftNext;
    logic            loadByte, frameErr;
    logic [GapW-1:0] gapCnt, gapNext;
    logic            eopNext;
    logic            pktSeen;

    logic [7:0] dataReg;
    logic       dataReady, frameError, endOfPacket;

    uart_baud #(
        .ClkFrequency(ClkFrequency),
        .TickRate    (Baud * Oversampling)
    ) uBaud (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(1'b1),
        .tick  (osTick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rxSync <= '1;
        else        rxSync <= {rxSync[0], bus.RxD};
    end

    assign rxs = rxSync[1];

    always_comb begin
        stateNext = state;
        osNext    = osCnt;
        bitNext   = bitCnt;
        shiftNext = shiftReg;
        loadByte  = 1'b0;
        frameErr  = 1'b0;
        if (osTick) begin
            unique case (state)
                StIdle: begin
                    if (!rxs) begin
                        stateNext = StStart;
                        osNext    = '0;
                    end
                end
                StStart: begin
                    if (osCnt == OsHalf) begin
                        if (!rxs) begin
                            stateNext = StData;
                            bitNext   = '0;
                            osNext    = '0;
                        end else begin
                            stateNext = StIdle;
                        end
                    end else begin
                        osNext = osCnt + OsW'(1);
                    end
                end
                StData: begin
                    if (osCnt == OsLast) begin
                        osNext    = '0;
                        shiftNext = {rxs, shiftReg[7:1]};
                        bitNext   = bitCnt + 3'd1;
                        if (bitCnt == 3'd7) stateNext = StStop;
                    end else begin
                        osNext = osCnt + OsW'(1);
                    end
                end
                StStop: begin
                    // Finishing at the stop-bit centre leaves half a bit to spot the next start.
                    if (osCnt == OsLast) begin
                        osNext = '0;
                        if (rxs) begin
                            loadByte  = 1'b1;
                            stateNext = StIdle;
                        end else begin
                            frameErr  = 1'b1;
                            stateNext = StBreak;
                        end
                    end else begin
                        osNext = osCnt + OsW'(1);
                    end
                end
                StBreak: begin
                    if (rxs) stateNext = StIdle;
                end
                default: stateNext = StIdle;
            endcase
        end
    end

    always_comb begin
        gapNext = gapCnt;
        eopNext = 1'b0;
        if (!(state == StIdle && rxs)) begin
            gapNext = '0;
        end else if (osTick && gapCnt != GapSat) begin
            gapNext = gapCnt + GapW'(1);
            eopNext = pktSeen && (gapCnt == GapSat - GapW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            osCnt    <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
        end else begin
            state    <= stateNext;
            osCnt    <= osNext;
            bitCnt   <= bitNext;
            shiftReg <= shiftNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataReg     <= '0;
            dataReady   <= 1'b0;
            frameError  <= 1'b0;
            gapCnt      <= '0;
            endOfPacket <= 1'b0;
            pktSeen     <= 1'b0;
        end else begin
            if (loadByte) dataReg <= shiftReg;
            dataReady   <= loadByte;
            frameError  <= frameErr;
            gapCnt      <= gapNext;
            endOfPacket <= eopNext;
            if (endOfPacket)    pktSeen <= 1'b0;
            else if (dataReady) pktSeen <= 1'b1;
        end
    end

    assign bus.RxD_data        = dataReg;
    assign bus.RxD_data_ready  = dataReady;
    assign bus.RxD_frame_error = frameError;
    assign bus.RxD_idle        = (gapCnt == GapSat);
    assign bus.RxD_endofpacket = endOfPacket;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames at 6 clk/bit, expected events queued at
// stimulus time and popped by an independent monitor when the receiver reports a byte.
module tb_uart_rx;
    localparam int unsigned ClkPerBit = 6;

    typedef struct packed {
        logic       isErr;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t expQ[$];
    int   nCompared;
    int   nFailed;
    int   pulseCount;
    int   eopCount;

    uart_rx_if bus ();

    uart_rx #(
        .ClkFrequency(12000000),
        .Baud        (2000000),
        .Oversampling(4),
        .GapBits     (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t want earlier", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nCompared++;
        if (act !== want) begin
            nFailed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Monitor: pops one expectation per reported byte or framing error.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.RxD_data_ready && bus.RxD_frame_error)
                check("ready_and_error_together", 32'd1, 32'd0);
            if (bus.RxD_data_ready || bus.RxD_frame_error) begin
                pulseCount++;
                if (expQ.size() == 0) begin
                    check("unexpected_event", {bus.RxD_frame_error, bus.RxD_data}, 32'h1ff);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check(bus.RxD_frame_error ? "frame_error_event" : "data_ready_event",
                          {bus.RxD_frame_error, bus.RxD_data}, {e.isErr, e.data});
                end
            end
            if (bus.RxD_endofpacket) eopCount++;
        end
    end

    task automatic driveBit(input logic v, input int unsigned clks);
        bus.RxD = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        driveBit(1'b0, ClkPerBit);
        for (int i = 0; i < 8; i++) driveBit(b[i], ClkPerBit);
        driveBit(stopBit, ClkPerBit);
    endtask

    task automatic expectByte(input logic [7:0] b);
        exp_t e;
        e.isErr = 1'b0;
        e.data  = b;
        expQ.push_back(e);
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 400 && expQ.size() != 0; i++) @(negedge clk);
        check(name, expQ.size(), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_data"},  bus.RxD_data, 0);
        check({tag, "_ready"}, bus.RxD_data_ready, 0);
        check({tag, "_ferr"},  bus.RxD_frame_error, 0);
        check({tag, "_idle"},  bus.RxD_idle, 0);
        check({tag, "_eop"},   bus.RxD_endofpacket, 0);
    endtask

    initial begin
        int   p0;
        int   e0;
        int   cnt;
        exp_t e;

        nCompared  = 0;
        nFailed    = 0;
        pulseCount = 0;
        eopCount   = 0;
        bus.RxD    = 1'b1;
        rst_n      = 1'b0;
        repeat (5) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("idle_after_reset", bus.RxD_idle, 1);

        // 1: single byte
        expectByte(8'hA5);
        sendByte(8'hA5, 1'b1);
        waitDrain("drain_a5");
        check("data_a5", bus.RxD_data, 8'hA5);

        // 2: back-to-back frames, one stop bit each
        expectByte(8'h00);
        expectByte(8'hFF);
        sendByte(8'h00, 1'b1);
        sendByte(8'hFF, 1'b1);
        waitDrain("drain_00_ff");
        repeat (30) @(negedge clk);

        // 3: short glitches on an idle line
        p0 = pulseCount;
        driveBit(1'b0, 1);
        driveBit(1'b1, 20);
        driveBit(1'b0, 2);
        driveBit(1'b1, 30);
        check("glitch_no_events", pulseCount - p0, 0);
        check("glitch_data_held", bus.RxD_data, 8'hFF);

        // 4: bad stop bit, long break, then a good byte
        e.isErr = 1'b1;
        e.data  = 8'hFF;
        expQ.push_back(e);
        sendByte(8'h55, 1'b0);
        driveBit(1'b0, 20 * ClkPerBit);
        driveBit(1'b1, 30);
        waitDrain("drain_ferr");
        check("ferr_data_held", bus.RxD_data, 8'hFF);
        expectByte(8'h3C);
        sendByte(8'h3C, 1'b1);
        waitDrain("drain_3c_after_break");
        repeat (30) @(negedge clk);

        // 5: reset in the middle of bit 3 of 0x81
        p0 = pulseCount;
        driveBit(1'b0, ClkPerBit);
        driveBit(1'b1, ClkPerBit);
        driveBit(1'b0, ClkPerBit);
        driveBit(1'b0, ClkPerBit);
        driveBit(1'b0, 3);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetOutputs("midframe_reset");
        driveBit(1'b1, 3);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("reset_no_events", pulseCount - p0, 0);
        expectByte(8'h3C);
        sendByte(8'h3C, 1'b1);
        waitDrain("drain_3c_after_reset");
        check("data_3c_after_reset", bus.RxD_data, 8'h3C);
        repeat (30) @(negedge clk);

        // 6: end-of-packet after a quiet gap
        e0 = eopCount;
        expectByte(8'h12);
        sendByte(8'h12, 1'b1);
        waitDrain("drain_12");
        check("idle_low_after_byte", bus.RxD_idle, 0);
        cnt = 0;
        while (eopCount == e0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("eop_seen", eopCount - e0, 1);
        check("eop_delay_in_range", (cnt >= 8 && cnt <= 15), 1);
        check("idle_high_at_eop", bus.RxD_idle, 1);
        repeat (100) @(negedge clk);
        check("eop_single_pulse", eopCount - e0, 1);
        check("idle_stays_high", bus.RxD_idle, 1);
        check("queue_empty_at_end", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end
endmodule
